// File: rtl/request_unit.sv
// request_unit: sequences instruction fetch, execute and data access, with retire and stall counters
module request_unit #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [31:0]      imemload,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic             halt,
    output logic [31:0]      instr_q,
    output logic             iREN,
    output logic             dREN,
    output logic             dWEN,
    output logic             pc_en,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] wait_cycles
);
    typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, wait_q;
    logic             stall;
    assign stall       = (state_q == FETCH && !ihit) || (state_q == MEM && !dhit);
    assign halted      = state_q == HALT;
    assign instr_count = count_q;
    assign wait_cycles = wait_q;
    // next state and memory requests; a store wins over a load when both decode
    always_comb begin
        state_d = state_q;
        iREN    = 1'b0;
        dREN    = 1'b0;
        dWEN    = 1'b0;
        pc_en   = 1'b0;
        case (state_q)
            FETCH: begin
                iREN = 1'b1;
                if (ihit) state_d = EXEC;
            end
            EXEC: begin
                if (halt) state_d = HALT;
                else if (MemRead || MemWrite) state_d = MEM;
                else begin
                    pc_en   = 1'b1;
                    state_d = FETCH;
                end
            end
            MEM: begin
                dWEN = MemWrite;
                dREN = MemRead & ~MemWrite;
                if (dhit) begin
                    pc_en   = 1'b1;
                    state_d = FETCH;
                end
            end
            default: ;
        endcase
    end
    // state register; reset drops any in-flight data request at once
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state_q <= FETCH;
        else       state_q <= state_d;
    end
    // instruction latch, loaded only by a completed fetch
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)                        instr_q <= '0;
        else if (state_q == FETCH && ihit) instr_q <= imemload;
    end
    // retire counter wraps, stall counter saturates
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count_q <= '0;
            wait_q  <= '0;
        end else begin
            count_q <= count_q + CNT_W'(pc_en);
            wait_q  <= (stall && !(&wait_q)) ? wait_q + CNT_W'(1) : wait_q;
        end
    end
endmodule

// File: tb/tb_request_unit.sv
// tb_request_unit: scenario tasks with a retire scoreboard for request_unit
module tb_request_unit;
    localparam logic [31:0] LUI  = 32'h3C010001;
    localparam logic [31:0] LW   = 32'h8C220004;
    localparam logic [31:0] SW   = 32'hAC220008;
    localparam logic [31:0] BOTH = 32'hEC220010;
    localparam logic [31:0] HLT  = 32'hFC000000;

    logic        CLK, nRST, ihit, dhit;
    logic [31:0] imemload;
    logic        MemRead, MemWrite, halt;
    logic [31:0] instr_q, instr_q4;
    logic        iREN, dREN, dWEN, pc_en, halted;
    logic        iREN4, dREN4, dWEN4, pc_en4, halted4;
    logic [15:0] instr_count, wait_cycles;
    logic [3:0]  instr_count4, wait_cycles4;
    logic [31:0] sb[$];
    int          checks = 0;
    int          failures = 0;

    // control-unit stand-in: opcode 0x23 load, 0x2b store, 0x3b both, 0x3f halt
    assign MemRead  = instr_q[31:26] == 6'h23 || instr_q[31:26] == 6'h3b;
    assign MemWrite = instr_q[31:26] == 6'h2b || instr_q[31:26] == 6'h3b;
    assign halt     = instr_q[31:26] == 6'h3f;

    request_unit dut (
        .CLK(CLK), .nRST(nRST), .imemload(imemload), .ihit(ihit), .dhit(dhit),
        .MemRead(MemRead), .MemWrite(MemWrite), .halt(halt), .instr_q(instr_q),
        .iREN(iREN), .dREN(dREN), .dWEN(dWEN), .pc_en(pc_en), .halted(halted),
        .instr_count(instr_count), .wait_cycles(wait_cycles)
    );

    request_unit #(.CNT_W(4)) dut4 (
        .CLK(CLK), .nRST(nRST), .imemload(imemload), .ihit(ihit), .dhit(dhit),
        .MemRead(MemRead), .MemWrite(MemWrite), .halt(halt), .instr_q(instr_q4),
        .iREN(iREN4), .dREN(dREN4), .dWEN(dWEN4), .pc_en(pc_en4), .halted(halted4),
        .instr_count(instr_count4), .wait_cycles(wait_cycles4)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset;
        @(negedge CLK);
        nRST = 1'b0; ihit = 1'b0; dhit = 1'b0; imemload = '0;
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic test_reset;
        @(negedge CLK);
        nRST = 1'b0; ihit = 1'b1; dhit = 1'b0; imemload = 32'h12345678;
        #1;
        checks++; if (iREN !== 1'b1) begin failures++; $display("FAIL reset_iren got=%b exp=1", iREN); end
        checks++; if ({dREN, dWEN, pc_en, halted} !== 4'b0) begin failures++; $display("FAIL reset_outs got=%b exp=0000", {dREN, dWEN, pc_en, halted}); end
        checks++; if (instr_q !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0", instr_q); end
        checks++; if (instr_count !== 16'd0 || wait_cycles !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", instr_count, wait_cycles); end
        @(negedge CLK);
        checks++; if (instr_q !== 32'h0 || iREN !== 1'b1) begin failures++; $display("FAIL reset_hold got=%h/%b exp=0/1", instr_q, iREN); end
        ihit = 1'b0; nRST = 1'b1;
        #1;
        checks++; if ({iREN, dREN, dWEN, pc_en} !== 4'b1000) begin failures++; $display("FAIL reset_release got=%b exp=1000", {iREN, dREN, dWEN, pc_en}); end
    endtask

    task automatic test_nonmem;
        logic [31:0] exp;
        do_reset();
        imemload = LUI; ihit = 1'b1; sb.push_back(LUI);
        @(negedge CLK);
        ihit = 1'b0; #1;
        checks++; if (pc_en !== 1'b1 || iREN !== 1'b0) begin failures++; $display("FAIL nonmem_exec got=%b%b exp=10", pc_en, iREN); end
        checks++;
        if (sb.size() == 0) begin failures++; $display("FAIL nonmem_sb got=empty exp=entry"); end
        else begin exp = sb.pop_front(); if (instr_q !== exp) begin failures++; $display("FAIL nonmem_instr got=%h exp=%h", instr_q, exp); end end
        @(negedge CLK);
        checks++; if (instr_count !== 16'd1 || wait_cycles !== 16'd0) begin failures++; $display("FAIL nonmem_cnt got=%0d/%0d exp=1/0", instr_count, wait_cycles); end
        checks++; if (pc_en !== 1'b0 || iREN !== 1'b1) begin failures++; $display("FAIL nonmem_fetch got=%b%b exp=01", pc_en, iREN); end
    endtask

    task automatic test_load;
        logic [31:0] exp;
        int c = 0, nren = 0, niren = 0, npc = 0;
        bit done = 0;
        do_reset();
        repeat (3) @(negedge CLK);
        imemload = LW; ihit = 1'b1; sb.push_back(LW);
        @(negedge CLK);
        ihit = 1'b0; #1;
        checks++; if ({iREN, dREN, dWEN, pc_en} !== 4'b0) begin failures++; $display("FAIL load_exec got=%b exp=0000", {iREN, dREN, dWEN, pc_en}); end
        @(negedge CLK);
        while (!done && c < 8) begin
            dhit = (c == 2); #1;
            if (dREN) nren++;
            if (iREN) niren++;
            if (pc_en) begin
                npc++; done = 1;
                checks++;
                if (sb.size() == 0) begin failures++; $display("FAIL load_sb got=empty exp=entry"); end
                else begin exp = sb.pop_front(); if (instr_q !== exp) begin failures++; $display("FAIL load_instr got=%h exp=%h", instr_q, exp); end end
            end
            @(negedge CLK);
            c++;
        end
        dhit = 1'b0;
        checks++; if (nren != 3) begin failures++; $display("FAIL load_dren_cycles got=%0d exp=3", nren); end
        checks++; if (niren != 0) begin failures++; $display("FAIL load_iren_in_mem got=%0d exp=0", niren); end
        checks++; if (npc != 1) begin failures++; $display("FAIL load_pcen got=%0d exp=1", npc); end
        checks++; if (wait_cycles !== 16'd5 || instr_count !== 16'd1) begin failures++; $display("FAIL load_cnt got=%0d/%0d exp=5/1", wait_cycles, instr_count); end
    endtask

    task automatic test_both;
        logic [31:0] exp;
        int c = 0, nwen = 0, nren = 0, npc = 0;
        bit done = 0;
        do_reset();
        imemload = BOTH; ihit = 1'b1; sb.push_back(BOTH);
        @(negedge CLK);
        ihit = 1'b0;
        @(negedge CLK);
        while (!done && c < 6) begin
            dhit = (c == 1); #1;
            if (dWEN) nwen++;
            if (dREN) nren++;
            if (pc_en) begin
                npc++; done = 1;
                checks++;
                if (sb.size() == 0) begin failures++; $display("FAIL both_sb got=empty exp=entry"); end
                else begin exp = sb.pop_front(); if (instr_q !== exp) begin failures++; $display("FAIL both_instr got=%h exp=%h", instr_q, exp); end end
            end
            @(negedge CLK);
            c++;
        end
        dhit = 1'b0;
        checks++; if (nwen != 2 || nren != 0) begin failures++; $display("FAIL both_wen_ren got=%0d/%0d exp=2/0", nwen, nren); end
        checks++; if (npc != 1 || iREN !== 1'b1) begin failures++; $display("FAIL both_retire got=%0d/%b exp=1/1", npc, iREN); end
    endtask

    task automatic test_halt;
        do_reset();
        imemload = HLT; ihit = 1'b1;
        @(negedge CLK);
        ihit = 1'b0; #1;
        checks++; if (halted !== 1'b0 || pc_en !== 1'b0) begin failures++; $display("FAIL halt_exec got=%b%b exp=00", halted, pc_en); end
        @(negedge CLK);
        checks++; if (halted !== 1'b1 || {iREN, dREN, dWEN} !== 3'b0) begin failures++; $display("FAIL halt_enter got=%b/%b exp=1/000", halted, {iREN, dREN, dWEN}); end
        for (int i = 0; i < 10; i++) begin
            ihit = 1'b1; dhit = 1'b1; imemload = $urandom;
            #1;
            checks++; if ({iREN, dREN, dWEN, pc_en} !== 4'b0) begin failures++; $display("FAIL halt_outs got=%b exp=0000", {iREN, dREN, dWEN, pc_en}); end
            @(negedge CLK);
            ihit = 1'b0; dhit = 1'b0;
            @(negedge CLK);
        end
        checks++; if (halted !== 1'b1 || instr_q !== HLT) begin failures++; $display("FAIL halt_sticky got=%b/%h exp=1/%h", halted, instr_q, HLT); end
        checks++; if (instr_count !== 16'd0 || wait_cycles !== 16'd0) begin failures++; $display("FAIL halt_cnt got=%0d/%0d exp=0/0", instr_count, wait_cycles); end
    endtask

    task automatic test_stray;
        logic [31:0] exp;
        do_reset();
        dhit = 1'b1;
        repeat (2) @(negedge CLK);
        checks++; if (iREN !== 1'b1 || instr_q !== 32'h0 || pc_en !== 1'b0) begin failures++; $display("FAIL stray_dhit got=%b/%h/%b exp=1/0/0", iREN, instr_q, pc_en); end
        checks++; if (wait_cycles !== 16'd2 || instr_count !== 16'd0) begin failures++; $display("FAIL stray_dhit_cnt got=%0d/%0d exp=2/0", wait_cycles, instr_count); end
        dhit = 1'b0; ihit = 1'b1; imemload = SW; sb.push_back(SW);
        @(negedge CLK);
        imemload = 32'hDEADBEEF; #1;
        checks++; if (pc_en !== 1'b0 || instr_q !== SW) begin failures++; $display("FAIL stray_exec got=%b/%h exp=0/%h", pc_en, instr_q, SW); end
        @(negedge CLK);
        repeat (2) begin
            #1;
            checks++; if (dWEN !== 1'b1 || pc_en !== 1'b0 || iREN !== 1'b0 || instr_q !== SW) begin failures++; $display("FAIL stray_ihit_mem got=%b%b%b/%h exp=100/%h", dWEN, pc_en, iREN, instr_q, SW); end
            @(negedge CLK);
        end
        dhit = 1'b1; #1;
        checks++;
        if (!pc_en) begin failures++; $display("FAIL stray_retire got=0 exp=1"); end
        else if (sb.size() == 0) begin failures++; $display("FAIL stray_sb got=empty exp=entry"); end
        else begin exp = sb.pop_front(); if (instr_q !== exp) begin failures++; $display("FAIL stray_instr got=%h exp=%h", instr_q, exp); end end
        @(negedge CLK);
        ihit = 1'b0; dhit = 1'b0;
        checks++; if (instr_q !== SW || iREN !== 1'b1 || instr_count !== 16'd1 || wait_cycles !== 16'd4) begin failures++; $display("FAIL stray_final got=%h/%b/%0d/%0d exp=%h/1/1/4", instr_q, iREN, instr_count, wait_cycles, SW); end
    endtask

    task automatic test_reset_mid_mem;
        do_reset();
        repeat (2) @(negedge CLK);
        imemload = SW; ihit = 1'b1;
        @(negedge CLK);
        ihit = 1'b0;
        @(negedge CLK);
        #1;
        checks++; if (dWEN !== 1'b1 || wait_cycles !== 16'd2) begin failures++; $display("FAIL midmem_pre got=%b/%0d exp=1/2", dWEN, wait_cycles); end
        #2 nRST = 1'b0;
        #1;
        checks++; if ({iREN, dREN, dWEN} !== 3'b100) begin failures++; $display("FAIL midmem_abort got=%b exp=100", {iREN, dREN, dWEN}); end
        checks++; if (instr_q !== 32'h0 || instr_count !== 16'd0 || wait_cycles !== 16'd0) begin failures++; $display("FAIL midmem_clear got=%h/%0d/%0d exp=0/0/0", instr_q, instr_count, wait_cycles); end
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic test_wrap;
        logic [31:0] exp;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            imemload = 32'h3C010000 | 32'(i); ihit = 1'b1; sb.push_back(32'h3C010000 | 32'(i));
            @(negedge CLK);
            ihit = 1'b0; #1;
            checks++;
            if (!pc_en) begin failures++; $display("FAIL wrap_pcen_%0d got=0 exp=1", i); end
            else if (sb.size() == 0) begin failures++; $display("FAIL wrap_sb got=empty exp=entry"); end
            else begin exp = sb.pop_front(); if (instr_q !== exp) begin failures++; $display("FAIL wrap_instr got=%h exp=%h", instr_q, exp); end end
            @(negedge CLK);
        end
        checks++; if (instr_count !== 16'd17 || instr_count4 !== 4'd1) begin failures++; $display("FAIL wrap_cnt got=%0d/%0d exp=17/1", instr_count, instr_count4); end
        checks++; if (wait_cycles !== 16'd0) begin failures++; $display("FAIL wrap_wait got=%0d exp=0", wait_cycles); end
    endtask

    task automatic test_saturate;
        do_reset();
        repeat (17) @(negedge CLK);
        checks++; if (wait_cycles4 !== 4'd15) begin failures++; $display("FAIL sat_wait4 got=%0d exp=15", wait_cycles4); end
        checks++; if (wait_cycles !== 16'd17) begin failures++; $display("FAIL sat_wait16 got=%0d exp=17", wait_cycles); end
    endtask

    initial begin
        nRST = 1'b0; ihit = 1'b0; dhit = 1'b0; imemload = '0;
        test_reset();
        test_nonmem();
        test_load();
        test_both();
        test_halt();
        test_stray();
        test_reset_mid_mem();
        test_wrap();
        test_saturate();
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL sb_drain got=%0d exp=0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
